// File: rtl/dmem_port_arbiter_pkg.sv
// Shared types and constants for the data-memory port arbiter.
package dmem_pkg;

    localparam int ADDR_W_DEF = 11;
    localparam int DATA_W_DEF = 16;

    // Transaction sequencer states
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_e;

    // Requester identifiers (also the grant vector bit positions)
    localparam logic REQ_CPU = 1'b0;
    localparam logic REQ_DBG = 1'b1;

endpackage

// File: rtl/dmem_port_arbiter_rr_arb2.sv
// Two-way round-robin arbiter with optional fixed CPU priority.
// The pointer remembers who was granted last; it moves only on update_i.
module rr_arb2
    import dmem_pkg::*;
#(
    parameter bit FIXED_PRIO = 1'b0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req_i,
    input  logic       update_i,
    output logic [1:0] gnt_o
);

    logic last_q;

    // Grant: lone requester wins; on a tie either CPU (fixed) or the one not served last
    always_comb begin
        gnt_o = 2'b00;
        case (req_i)
            2'b01:   gnt_o = 2'b01;
            2'b10:   gnt_o = 2'b10;
            2'b11: begin
                if (FIXED_PRIO || (last_q == REQ_DBG)) gnt_o = 2'b01;
                else                                   gnt_o = 2'b10;
            end
            default: gnt_o = 2'b00;
        endcase
    end

    // Last-grant pointer; resets as if DBG was served last so CPU wins the first tie
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)        last_q <= REQ_DBG;
        else if (update_i) last_q <= gnt_o[1] ? REQ_DBG : REQ_CPU;
    end

endmodule

// File: rtl/dmem_port_arbiter.sv
// Serialises CPU and debug-loader accesses onto one single-port data BRAM.
// One transaction at a time: accept -> issue -> (read latency wait) -> response pulse.
module dmem_port_arbiter
    import dmem_pkg::*;
#(
    parameter int ADDR_W     = ADDR_W_DEF,
    parameter int DATA_W     = DATA_W_DEF,
    parameter int RD_LAT     = 1,
    parameter int FIXED_PRIO = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    // CPU load/store unit
    input  logic              cpu_req_valid,
    output logic              cpu_req_ready,
    input  logic              cpu_req_we,
    input  logic [ADDR_W-1:0] cpu_req_addr,
    input  logic [DATA_W-1:0] cpu_req_wdata,
    output logic              cpu_rsp_valid,
    output logic [DATA_W-1:0] cpu_rsp_rdata,
    // Debug / program loader
    input  logic              dbg_req_valid,
    output logic              dbg_req_ready,
    input  logic              dbg_req_we,
    input  logic [ADDR_W-1:0] dbg_req_addr,
    input  logic [DATA_W-1:0] dbg_req_wdata,
    output logic              dbg_rsp_valid,
    output logic [DATA_W-1:0] dbg_rsp_rdata,
    // BRAM port
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_din,
    input  logic [DATA_W-1:0] mem_dout
);

    localparam logic [2:0] RD_LAT_C = 3'(RD_LAT);

    state_e            state_q, state_d;
    logic [2:0]        lat_q, lat_d;
    logic              owner_q;
    logic              we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] din_q;
    logic [DATA_W-1:0] cpu_rdata_q, dbg_rdata_q;

    logic [1:0]        gnt;
    logic              idle;
    logic              accept;
    logic              sel_dbg;
    logic              sel_we;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;
    logic              rd_done;

    rr_arb2 #(
        .FIXED_PRIO (FIXED_PRIO != 0)
    ) u_arb (
        .clk      (clk),
        .rst_n    (rst_n),
        .req_i    ({dbg_req_valid, cpu_req_valid}),
        .update_i (accept),
        .gnt_o    (gnt)
    );

    // Ready goes only to the arbitration winner and only while idle
    always_comb begin
        idle          = (state_q == ST_IDLE);
        cpu_req_ready = idle && gnt[0];
        dbg_req_ready = idle && gnt[1];
        accept        = (cpu_req_valid && cpu_req_ready) || (dbg_req_valid && dbg_req_ready);
        sel_dbg       = dbg_req_ready;
        sel_we        = sel_dbg ? dbg_req_we    : cpu_req_we;
        sel_addr      = sel_dbg ? dbg_req_addr  : cpu_req_addr;
        sel_wdata     = sel_dbg ? dbg_req_wdata : cpu_req_wdata;
        rd_done       = (state_q == ST_WAIT) && (lat_q == 3'd1);
    end

    // Next-state and latency counter
    always_comb begin
        state_d = state_q;
        lat_d   = lat_q;
        case (state_q)
            ST_IDLE:  if (accept) state_d = ST_ISSUE;
            ST_ISSUE: begin
                if (we_q) begin
                    state_d = ST_RESP;
                end else begin
                    lat_d   = RD_LAT_C;
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                lat_d = lat_q - 3'd1;
                if (lat_q == 3'd1) state_d = ST_RESP;
            end
            ST_RESP:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            lat_q   <= 3'd0;
        end else begin
            state_q <= state_d;
            lat_q   <= lat_d;
        end
    end

    // Capture on accept; addr/din double as the BRAM pin registers so they hold between accesses
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            owner_q <= REQ_CPU;
            we_q    <= 1'b0;
            addr_q  <= '0;
            din_q   <= '0;
        end else if (accept) begin
            owner_q <= sel_dbg ? REQ_DBG : REQ_CPU;
            we_q    <= sel_we;
            addr_q  <= sel_addr;
            if (sel_we) din_q <= sel_wdata;
        end
    end

    // Read data lands in the owner's register only; the other requester's value is kept
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cpu_rdata_q <= '0;
            dbg_rdata_q <= '0;
        end else if (rd_done) begin
            if (owner_q == REQ_DBG) dbg_rdata_q <= mem_dout;
            else                    cpu_rdata_q <= mem_dout;
        end
    end

    // BRAM pins and response demux
    always_comb begin
        mem_en        = (state_q == ST_ISSUE) || (state_q == ST_WAIT);
        mem_we        = (state_q == ST_ISSUE) && we_q;
        mem_addr      = addr_q;
        mem_din       = din_q;
        cpu_rsp_valid = (state_q == ST_RESP) && (owner_q == REQ_CPU);
        dbg_rsp_valid = (state_q == ST_RESP) && (owner_q == REQ_DBG);
        cpu_rsp_rdata = cpu_rdata_q;
        dbg_rsp_rdata = dbg_rdata_q;
    end

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Directed bench: DUT 0 is round-robin with RD_LAT=1, DUT 1 is fixed-priority with RD_LAT=3.
// Each DUT has its own behavioural BRAM with matching read latency.
module tb_dmem_port_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n   [2];
    logic        cpu_v   [2];
    logic        cpu_we  [2];
    logic [10:0] cpu_a   [2];
    logic [15:0] cpu_wd  [2];
    logic        cpu_rdy [2];
    logic        cpu_rv  [2];
    logic [15:0] cpu_rd  [2];
    logic        dbg_v   [2];
    logic        dbg_we  [2];
    logic [10:0] dbg_a   [2];
    logic [15:0] dbg_wd  [2];
    logic        dbg_rdy [2];
    logic        dbg_rv  [2];
    logic [15:0] dbg_rd  [2];
    logic        m_en    [2];
    logic        m_we    [2];
    logic [10:0] m_addr  [2];
    logic [15:0] m_din   [2];
    logic [15:0] m_dout  [2];

    int passed = 0;
    int total  = 0;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        localparam int RDL = (g == 0) ? 1 : 3;
        localparam int FP  = (g == 0) ? 0 : 1;

        logic [15:0] mem  [2048];
        logic [15:0] pipe [4];

        dmem_port_arbiter #(
            .ADDR_W(11), .DATA_W(16), .RD_LAT(RDL), .FIXED_PRIO(FP)
        ) u_dut (
            .clk           (clk),
            .rst_n         (rst_n[g]),
            .cpu_req_valid (cpu_v[g]),
            .cpu_req_ready (cpu_rdy[g]),
            .cpu_req_we    (cpu_we[g]),
            .cpu_req_addr  (cpu_a[g]),
            .cpu_req_wdata (cpu_wd[g]),
            .cpu_rsp_valid (cpu_rv[g]),
            .cpu_rsp_rdata (cpu_rd[g]),
            .dbg_req_valid (dbg_v[g]),
            .dbg_req_ready (dbg_rdy[g]),
            .dbg_req_we    (dbg_we[g]),
            .dbg_req_addr  (dbg_a[g]),
            .dbg_req_wdata (dbg_wd[g]),
            .dbg_rsp_valid (dbg_rv[g]),
            .dbg_rsp_rdata (dbg_rd[g]),
            .mem_en        (m_en[g]),
            .mem_we        (m_we[g]),
            .mem_addr      (m_addr[g]),
            .mem_din       (m_din[g]),
            .mem_dout      (m_dout[g])
        );

        // Read-first BRAM; extra pipeline stages model the optional output registers
        always @(posedge clk) begin
            if (m_en[g]) begin
                if (m_we[g]) mem[m_addr[g]] <= m_din[g];
                pipe[0] <= mem[m_addr[g]];
            end
            for (int i = 1; i < 4; i++) pipe[i] <= pipe[i-1];
        end
        assign m_dout[g] = pipe[RDL-1];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total = total + 1;
        assert (obs === exp) passed = passed + 1;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic do_reset(input int d);
        rst_n[d] = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n[d] = 1'b1;
        #1;
    endtask

    // One transaction on an idle DUT; checks BRAM pins in T+1, response latency, pulse width
    task automatic xact(input int d, input bit dbg, input bit we, input logic [10:0] a,
                        input logic [15:0] wd, input int lat, input bit chk_rd,
                        input logic [15:0] rexp, input string tag);
        int k;
        int other;
        if (dbg) begin
            dbg_we[d] = we; dbg_a[d] = a; dbg_wd[d] = wd; dbg_v[d] = 1'b1;
        end else begin
            cpu_we[d] = we; cpu_a[d] = a; cpu_wd[d] = wd; cpu_v[d] = 1'b1;
        end
        #1;
        k = 0;
        while (!(dbg ? dbg_rdy[d] : cpu_rdy[d]) && k < 20) begin
            @(posedge clk); #1; k++;
        end
        chk({tag, "_ready"}, 32'(dbg ? dbg_rdy[d] : cpu_rdy[d]), 1);
        @(posedge clk); #1;
        cpu_v[d] = 1'b0; dbg_v[d] = 1'b0;
        #1;
        chk({tag, "_mem_en"},   32'(m_en[d]),   1);
        chk({tag, "_mem_we"},   32'(m_we[d]),   32'(we));
        chk({tag, "_mem_addr"}, 32'(m_addr[d]), 32'(a));
        if (we) chk({tag, "_mem_din"}, 32'(m_din[d]), 32'(wd));
        k = 1; other = 0;
        while (!(dbg ? dbg_rv[d] : cpu_rv[d]) && k < 20) begin
            if (dbg ? cpu_rv[d] : dbg_rv[d]) other++;
            @(posedge clk); #1; k++;
        end
        chk({tag, "_latency"}, 32'(k), 32'(lat));
        chk({tag, "_other_rsp"}, 32'(other), 0);
        if (chk_rd) chk({tag, "_rdata"}, 32'(dbg ? dbg_rd[d] : cpu_rd[d]), 32'(rexp));
        @(posedge clk); #1;
        chk({tag, "_pulse_end"}, 32'(dbg ? dbg_rv[d] : cpu_rv[d]), 0);
    endtask

    // Both requesters read concurrently; records grant order (bit i = 1 means DBG got grant i)
    task automatic contend(input int d, input int n, input bit keep, input logic [10:0] ca,
                           input logic [10:0] da, output logic [7:0] ord, output int nc,
                           output int nd, output int nboth, output int cnt);
        int  tail;
        int  cyc;
        bit  ac, ad;
        ord = '0; nc = 0; nd = 0; nboth = 0; cnt = 0; tail = 0; cyc = 0;
        cpu_we[d] = 1'b0; cpu_a[d] = ca; cpu_v[d] = 1'b1;
        dbg_we[d] = 1'b0; dbg_a[d] = da; dbg_v[d] = 1'b1;
        #1;
        while (tail < 12 && cyc < 300) begin
            if (cpu_rv[d]) nc++;
            if (dbg_rv[d]) nd++;
            if (cpu_rdy[d] && dbg_rdy[d]) nboth++;
            ac = cpu_v[d] && cpu_rdy[d];
            ad = dbg_v[d] && dbg_rdy[d];
            @(posedge clk); #1;
            if ((ac || ad) && cnt < 8) begin
                ord[cnt[2:0]] = ad;
                cnt++;
            end
            if (ac && !keep) cpu_v[d] = 1'b0;
            if (ad && !keep) dbg_v[d] = 1'b0;
            if (cnt >= n) begin
                cpu_v[d] = 1'b0; dbg_v[d] = 1'b0; tail++;
            end
            cyc++;
            #1;
        end
    endtask

    logic [7:0] ord;
    int nc, nd, nboth, cnt, k;

    initial begin
        for (int d = 0; d < 2; d++) begin
            rst_n[d] = 1'b0;
            cpu_v[d] = 1'b0; cpu_we[d] = 1'b0; cpu_a[d] = '0; cpu_wd[d] = '0;
            dbg_v[d] = 1'b0; dbg_we[d] = 1'b0; dbg_a[d] = '0; dbg_wd[d] = '0;
        end
        repeat (3) @(posedge clk);
        #1;
        chk("rst_mem_en",   32'(m_en[0]),   0);
        chk("rst_mem_we",   32'(m_we[0]),   0);
        chk("rst_mem_addr", 32'(m_addr[0]), 0);
        chk("rst_mem_din",  32'(m_din[0]),  0);
        chk("rst_cpu_rd",   32'(cpu_rd[0]), 0);
        chk("rst_rsp",      32'({cpu_rv[0], dbg_rv[0]}), 0);
        rst_n[0] = 1'b1; rst_n[1] = 1'b1;
        #1;
        chk("idle_ready",   32'({cpu_rdy[0], dbg_rdy[0]}), 0);
        @(posedge clk); #1;

        // Write then read back through the CPU port
        xact(0, 1'b0, 1'b1, 11'h005, 16'hBEEF, 2, 1'b0, 16'h0000, "t1_cpu_wr");
        xact(0, 1'b0, 1'b0, 11'h005, 16'h0000, 3, 1'b1, 16'hBEEF, "t2_cpu_rd");

        // Top-of-memory write from DBG, read back by CPU
        xact(0, 1'b1, 1'b1, 11'h7FF, 16'h1234, 2, 1'b0, 16'h0000, "t5_dbg_wr");
        chk("t5_dbg_rd_kept", 32'(dbg_rd[0]), 0);
        xact(0, 1'b0, 1'b0, 11'h7FF, 16'h0000, 3, 1'b1, 16'h1234, "t5_cpu_rd");
        chk("t5_dbg_rd_kept2", 32'(dbg_rd[0]), 0);

        // Seed data for the contention test, then start from a fresh reset
        xact(0, 1'b1, 1'b1, 11'h010, 16'h1111, 2, 1'b0, 16'h0000, "t3_seed_a");
        xact(0, 1'b0, 1'b1, 11'h020, 16'h2222, 2, 1'b0, 16'h0000, "t3_seed_b");
        do_reset(0);
        chk("t3_rst_cpu_rd", 32'(cpu_rd[0]), 0);
        contend(0, 2, 1'b0, 11'h010, 11'h020, ord, nc, nd, nboth, cnt);
        chk("t3_grants",    32'(cnt), 2);
        chk("t3_order",     32'(ord[1:0]), 32'h2);
        chk("t3_cpu_pulse", 32'(nc), 1);
        chk("t3_dbg_pulse", 32'(nd), 1);
        chk("t3_both_rdy",  32'(nboth), 0);
        chk("t3_cpu_data",  32'(cpu_rd[0]), 32'h1111);
        chk("t3_dbg_data",  32'(dbg_rd[0]), 32'h2222);

        // Continuous contention, round-robin: C,D,C,D...
        contend(0, 8, 1'b1, 11'h010, 11'h020, ord, nc, nd, nboth, cnt);
        chk("t4_rr_grants", 32'(cnt), 8);
        chk("t4_rr_order",  32'(ord), 32'hAA);
        chk("t4_rr_cpu",    32'(nc), 4);
        chk("t4_rr_dbg",    32'(nd), 4);
        chk("t4_rr_both",   32'(nboth), 0);

        // Reset during a read's wait state
        cpu_we[0] = 1'b0; cpu_a[0] = 11'h005; cpu_v[0] = 1'b1;
        #1;
        k = 0;
        while (!cpu_rdy[0] && k < 20) begin @(posedge clk); #1; k++; end
        chk("t6_ready", 32'(cpu_rdy[0]), 1);
        @(posedge clk); #1;
        cpu_v[0] = 1'b0;
        @(posedge clk); #1;
        chk("t6_wait_en", 32'(m_en[0]), 1);
        rst_n[0] = 1'b0;
        #1;
        chk("t6_abort_en",   32'(m_en[0]),   0);
        chk("t6_abort_addr", 32'(m_addr[0]), 0);
        nc = 0;
        for (int i = 0; i < 3; i++) begin
            if (cpu_rv[0] || dbg_rv[0]) nc++;
            @(posedge clk); #1;
        end
        chk("t6_no_rsp", 32'(nc), 0);
        rst_n[0] = 1'b1;
        #1;
        chk("t6_cpu_rd_rst", 32'(cpu_rd[0]), 0);
        @(posedge clk); #1;
        xact(0, 1'b0, 1'b0, 11'h005, 16'h0000, 3, 1'b1, 16'hBEEF, "t6_after");

        // RD_LAT=3, fixed priority instance
        xact(1, 1'b0, 1'b1, 11'h005, 16'hBEEF, 2, 1'b0, 16'h0000, "t2b_cpu_wr");
        xact(1, 1'b0, 1'b0, 11'h005, 16'h0000, 5, 1'b1, 16'hBEEF, "t2b_cpu_rd3");
        contend(1, 8, 1'b1, 11'h005, 11'h005, ord, nc, nd, nboth, cnt);
        chk("t4_fp_grants", 32'(cnt), 8);
        chk("t4_fp_order",  32'(ord), 0);
        chk("t4_fp_cpu",    32'(nc), 8);
        chk("t4_fp_dbg",    32'(nd), 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
